// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU load/store path
// and two secondary masters (M0 display readback, M1 debug loader).
// The CPU has fixed priority. M0 and M1 share idle cycles round-robin. A
// per-master wait counter forces a starved master through by stalling the
// CPU for one cycle.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic              clk3,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FORCE0 = 2'd1,
        FORCE1 = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_M0   = 2'd2,
        OWN_M1   = 2'd3
    } owner_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    fsm_t              fsm;
    fsm_t              fsm_next;
    owner_t            owner;
    logic              rr;
    logic              rr_next;
    logic [WAIT_W-1:0] wait0;
    logic [WAIT_W-1:0] wait1;
    logic [WAIT_W-1:0] wait0_next;
    logic [WAIT_W-1:0] wait1_next;
    logic              grant0;
    logic              grant1;
    logic              sat0;
    logic              sat1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // Pick who owns the RAM port this cycle: a forced master, else CPU, else the secondaries.
    always_comb begin
        owner = OWN_NONE;
        case (fsm)
            FORCE0: begin
                if (m0_req) owner = OWN_M0;
            end
            FORCE1: begin
                if (m1_req) owner = OWN_M1;
            end
            default: begin
                if (cpu_req)                owner = OWN_CPU;
                else if (m0_req && m1_req)  owner = rr ? OWN_M1 : OWN_M0;
                else if (m0_req)            owner = OWN_M0;
                else if (m1_req)            owner = OWN_M1;
            end
        endcase
    end

    // Steer the owner's address, data and write enable onto the RAM port; an idle port shows cpu_addr.
    always_comb begin
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_we    = 1'b0;
        case (owner)
            OWN_CPU: begin
                sel_we = cpu_we;
            end
            OWN_M0: begin
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
                sel_we    = m0_we;
            end
            OWN_M1: begin
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
                sel_we    = m1_we;
            end
            default: begin
                sel_we = 1'b0;
            end
        endcase
    end

    // Drive outputs, holding every one of them at zero while reset is asserted.
    always_comb begin
        mem_addr  = rst ? '0 : sel_addr;
        mem_wdata = rst ? '0 : sel_wdata;
        mem_we    = rst ? 1'b0 : sel_we;
        cpu_stall = !rst && (fsm != NORMAL);
        m0_ack    = !rst && (owner == OWN_M0);
        m1_ack    = !rst && (owner == OWN_M1);
        cpu_rdata = (!rst && owner == OWN_CPU) ? mem_rdata : '0;
        m0_rdata  = (!rst && owner == OWN_M0)  ? mem_rdata : '0;
        m1_rdata  = (!rst && owner == OWN_M1)  ? mem_rdata : '0;
    end

    // Compute the round-robin pointer, starvation counters and next FSM state.
    always_comb begin
        grant0 = (owner == OWN_M0);
        grant1 = (owner == OWN_M1);

        rr_next = rr;
        if (grant0)      rr_next = 1'b1;
        else if (grant1) rr_next = 1'b0;

        if (grant0 || !m0_req)     wait0_next = '0;
        else if (wait0 == WAIT_MAX) wait0_next = wait0;
        else                        wait0_next = wait0 + WAIT_W'(1);

        if (grant1 || !m1_req)     wait1_next = '0;
        else if (wait1 == WAIT_MAX) wait1_next = wait1;
        else                        wait1_next = wait1 + WAIT_W'(1);

        sat0 = (wait0_next == WAIT_MAX);
        sat1 = (wait1_next == WAIT_MAX);

        fsm_next = NORMAL;
        case (fsm)
            NORMAL: begin
                if (sat0 && sat1) fsm_next = rr ? FORCE1 : FORCE0;
                else if (sat0)    fsm_next = FORCE0;
                else if (sat1)    fsm_next = FORCE1;
            end
            FORCE0: begin
                if (sat1) fsm_next = FORCE1;
            end
            FORCE1: begin
                if (sat0) fsm_next = FORCE0;
            end
            default: begin
                fsm_next = NORMAL;
            end
        endcase
    end

    // Register arbitration state; reset drops any in-flight access and clears the counters.
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) begin
            fsm   <= NORMAL;
            rr    <= 1'b0;
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            fsm   <= fsm_next;
            rr    <= rr_next;
            wait0 <= wait0_next;
            wait1 <= wait1_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a behavioural model
// that tracks pending-cycle counts per master and a small RAM image.
module tb_dmem_arbiter;

    localparam int MAXW = 15;

    logic        clk3 = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        m0_req, m0_we, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int errors = 0;
    int checks = 0;

    // RAM fixture driven by the DUT's memory port
    logic [31:0] fx_ram [0:63];
    logic [63:0] fx_written = '0;

    // Behavioural model state
    logic [31:0] m_ram [0:63];
    logic [63:0] m_written = '0;
    int          cnt0 = 0;
    int          cnt1 = 0;
    int          forced = -1;
    bit          rr_m = 1'b0;

    // Expected values for the current cycle (owner: -1 none, 0 M0, 1 M1, 2 CPU)
    int          e_owner = -1;
    bit          e_stall, e_we;
    logic [31:0] e_addr, e_wdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .clk3      (clk3),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk3 = ~clk3;

    function automatic logic [31:0] init_word(input logic [5:0] i);
        return 32'hA500_0000 | {26'b0, i};
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return m_written[a[7:2]] ? m_ram[a[7:2]] : init_word(a[7:2]);
    endfunction

    assign mem_rdata = fx_written[mem_addr[7:2]] ? fx_ram[mem_addr[7:2]] : init_word(mem_addr[7:2]);

    // RAM fixture write port
    always @(posedge clk3) begin
        if (mem_we) begin
            fx_ram[mem_addr[7:2]]     <= mem_wdata;
            fx_written[mem_addr[7:2]] <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(
        input bit c_req, input bit c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
        input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
        input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk3);
        #1;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // Owner rules: a starved master is forced; otherwise CPU first, then secondaries round-robin
    task automatic compute_expect();
        logic [31:0] own_addr;
        e_stall = (forced >= 0);
        if (forced == 0)           e_owner = m0_req ? 0 : -1;
        else if (forced == 1)      e_owner = m1_req ? 1 : -1;
        else if (cpu_req)          e_owner = 2;
        else if (m0_req && m1_req) e_owner = rr_m ? 1 : 0;
        else if (m0_req)           e_owner = 0;
        else if (m1_req)           e_owner = 1;
        else                       e_owner = -1;
        case (e_owner)
            0:       begin own_addr = m0_addr;  e_wdata = m0_wdata;  e_we = m0_we;  end
            1:       begin own_addr = m1_addr;  e_wdata = m1_wdata;  e_we = m1_we;  end
            2:       begin own_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_we; end
            default: begin own_addr = cpu_addr; e_wdata = cpu_wdata; e_we = 1'b0;   end
        endcase
        e_addr = own_addr;
    endtask

    // Model update at each edge: RAM image, round-robin pointer, pending counts, forced master
    always @(posedge clk3 or posedge rst) begin
        if (rst) begin
            cnt0 = 0; cnt1 = 0; forced = -1; rr_m = 1'b0; e_owner = -1; e_we = 1'b0;
        end else begin
            if (e_we) begin
                m_ram[e_addr[7:2]]     = e_wdata;
                m_written[e_addr[7:2]] = 1'b1;
            end
            if (e_owner == 0)      rr_m = 1'b1;
            else if (e_owner == 1) rr_m = 1'b0;
            cnt0 = (e_owner == 0 || !m0_req) ? 0 : ((cnt0 < MAXW) ? cnt0 + 1 : MAXW);
            cnt1 = (e_owner == 1 || !m1_req) ? 0 : ((cnt1 < MAXW) ? cnt1 + 1 : MAXW);
            if (cnt0 == MAXW && cnt1 == MAXW) forced = rr_m ? 1 : 0;
            else if (cnt0 == MAXW)            forced = 0;
            else if (cnt1 == MAXW)            forced = 1;
            else                              forced = -1;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk3) begin
        if (rst) begin
            e_owner = -1; e_we = 1'b0;
            checkOutput("cyc_rst_mem_we",    32'(mem_we),    32'd0);
            checkOutput("cyc_rst_stall",     32'(cpu_stall), 32'd0);
            checkOutput("cyc_rst_m0_ack",    32'(m0_ack),    32'd0);
            checkOutput("cyc_rst_m1_ack",    32'(m1_ack),    32'd0);
            checkOutput("cyc_rst_mem_addr",  mem_addr,       32'd0);
        end else begin
            compute_expect();
            checkOutput("cyc_stall",     32'(cpu_stall), 32'(e_stall));
            checkOutput("cyc_mem_we",    32'(mem_we),    32'(e_we));
            checkOutput("cyc_m0_ack",    32'(m0_ack),    32'(e_owner == 0));
            checkOutput("cyc_m1_ack",    32'(m1_ack),    32'(e_owner == 1));
            checkOutput("cyc_mem_addr",  mem_addr,       e_addr);
            checkOutput("cyc_cpu_rdata", cpu_rdata, (e_owner == 2) ? model_word(e_addr) : 32'd0);
            checkOutput("cyc_m0_rdata",  m0_rdata,  (e_owner == 0) ? model_word(e_addr) : 32'd0);
            checkOutput("cyc_m1_rdata",  m1_rdata,  (e_owner == 1) ? model_word(e_addr) : 32'd0);
            if (e_owner >= 0)
                checkOutput("cyc_mem_wdata", mem_wdata, e_wdata);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h2222_2222;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;

        // Reset state: all outputs held at zero despite active requests
        #2;
        checkOutput("reset_mem_we",   32'(mem_we),    32'd0);
        checkOutput("reset_mem_addr", mem_addr,       32'd0);
        checkOutput("reset_stall",    32'(cpu_stall), 32'd0);
        checkOutput("reset_m0_ack",   32'(m0_ack),    32'd0);

        applyStimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        rst = 1'b0;

        // CPU store then load of 0x10
        applyStimulus(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        checkOutput("cpu_wr_mem_we",   32'(mem_we),    32'd1);
        checkOutput("cpu_wr_mem_addr", mem_addr,       32'h10);
        checkOutput("cpu_wr_wdata",    mem_wdata,      32'hDEADBEEF);
        applyStimulus(1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        checkOutput("cpu_rd_data",  cpu_rdata,      32'hDEADBEEF);
        checkOutput("cpu_rd_stall", 32'(cpu_stall), 32'd0);

        // Idle round-robin: M0 first after reset, then alternating
        applyStimulus(0,0,32'h0,32'h0, 1,0,32'h20,32'h0, 1,0,32'h24,32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk3);
            checkOutput("rr_m0_ack", 32'(m0_ack), 32'((i % 2) == 0));
            checkOutput("rr_m1_ack", 32'(m1_ack), 32'((i % 2) == 1));
            if (i == 0) checkOutput("rr_m0_rdata", m0_rdata, 32'hA500_0008);
            if (i == 1) checkOutput("rr_m1_rdata", m1_rdata, 32'hA500_0009);
        end
        applyStimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);

        // Starvation of M0 under continuous CPU traffic
        applyStimulus(1,0,32'h10,32'h0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk3);
            if (m0_ack) begin k = c; break; end
        end
        checkOutput("starve_ack_cycle", 32'(k),          32'd16);
        checkOutput("starve_stall",     32'(cpu_stall),  32'd1);
        checkOutput("starve_m0_rdata",  m0_rdata,        32'hA500_0010);
        applyStimulus(1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        checkOutput("starve_after_stall", 32'(cpu_stall), 32'd0);
        checkOutput("starve_after_cpu",   cpu_rdata,      32'hDEADBEEF);

        // Single M1 access in an idle cycle sets the pointer back to M0
        applyStimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,0,32'h44,32'h0);
        @(negedge clk3);
        checkOutput("prep_m1_ack", 32'(m1_ack), 32'd1);

        // Double starvation: FORCE0 then FORCE1, two stall cycles
        applyStimulus(1,0,32'h10,32'h0, 1,0,32'h40,32'h0, 1,0,32'h44,32'h0);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk3);
            if (cpu_stall) begin k = c; break; end
        end
        checkOutput("dbl_first_stall_cycle", 32'(k),      32'd16);
        checkOutput("dbl_f0_m0_ack",         32'(m0_ack), 32'd1);
        checkOutput("dbl_f0_m1_ack",         32'(m1_ack), 32'd0);
        checkOutput("dbl_f0_m0_rdata",       m0_rdata,    32'hA500_0010);
        applyStimulus(1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 1,0,32'h44,32'h0);
        @(negedge clk3);
        checkOutput("dbl_f1_stall",    32'(cpu_stall), 32'd1);
        checkOutput("dbl_f1_m1_ack",   32'(m1_ack),    32'd1);
        checkOutput("dbl_f1_m1_rdata", m1_rdata,       32'hA500_0011);
        applyStimulus(1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        checkOutput("dbl_third_stall", 32'(cpu_stall), 32'd0);

        // M1 starves, then drops its request in the forced cycle
        applyStimulus(1,1,32'h14,32'h1234_5678, 0,0,32'h0,32'h0, 1,1,32'h48,32'h55AA_55AA);
        k = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk3);
            if (cpu_stall || m1_ack) k++;
        end
        checkOutput("drop_early_events", 32'(k), 32'd0);
        applyStimulus(1,1,32'h14,32'h1234_5678, 0,0,32'h0,32'h0, 0,1,32'h48,32'h55AA_55AA);
        @(negedge clk3);
        checkOutput("drop_stall",  32'(cpu_stall), 32'd1);
        checkOutput("drop_mem_we", 32'(mem_we),    32'd0);
        checkOutput("drop_m1_ack", 32'(m1_ack),    32'd0);
        @(negedge clk3);
        checkOutput("drop_after_stall",  32'(cpu_stall), 32'd0);
        checkOutput("drop_after_mem_we", 32'(mem_we),    32'd1);
        checkOutput("drop_after_addr",   mem_addr,       32'h14);

        // M0 access in an idle cycle moves the pointer to M1
        applyStimulus(0,0,32'h0,32'h0, 1,0,32'h4C,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        checkOutput("prep_m0_ack", 32'(m0_ack), 32'd1);

        // Async reset in the middle of a forced M0 write
        applyStimulus(1,0,32'h10,32'h0, 1,1,32'h4C,32'hCAFE_F00D, 0,0,32'h0,32'h0);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk3);
            if (cpu_stall) begin k = c; break; end
        end
        checkOutput("rstmid_stall_cycle", 32'(k),      32'd16);
        checkOutput("rstmid_pre_mem_we",  32'(mem_we), 32'd1);
        checkOutput("rstmid_pre_m0_ack",  32'(m0_ack), 32'd1);
        checkOutput("rstmid_pre_addr",    mem_addr,    32'h4C);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_mem_we",   32'(mem_we),    32'd0);
        checkOutput("rstmid_stall",    32'(cpu_stall), 32'd0);
        checkOutput("rstmid_m0_ack",   32'(m0_ack),    32'd0);
        checkOutput("rstmid_mem_addr", mem_addr,       32'd0);
        @(negedge clk3);
        applyStimulus(0,0,32'h0,32'h0, 1,0,32'h4C,32'h0, 1,0,32'h50,32'h0);
        rst = 1'b0;
        @(negedge clk3);
        checkOutput("post_rst_m0_ack",   32'(m0_ack),    32'd1);
        checkOutput("post_rst_m1_ack",   32'(m1_ack),    32'd0);
        checkOutput("post_rst_no_write", m0_rdata,       32'hA500_0013);
        checkOutput("post_rst_stall",    32'(cpu_stall), 32'd0);
        @(negedge clk3);
        checkOutput("post_rst_m1_turn",  32'(m1_ack),    32'd1);
        checkOutput("post_rst_m1_rdata", m1_rdata,       32'hA500_0014);

        applyStimulus(0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        @(negedge clk3);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
